am_flow_scheduler: RTL and testbench
====================================

# am_flow_scheduler

Sequences the 257-bit block stream feeding the two-flow distributor. It periodically inserts a group of alignment-marker (AM) blocks between runs of data blocks, and backpressures the upstream block source while a group is being inserted. Every emitted beat is tagged with its target flow, alternating 0/1, so the downstream distributor stays in lock-step with AM placement.

## Interface
- BITS_BLOCK, 257, width of one block
- MAX_BLOCKS_AM, 40, AM blocks per insertion group; must be even and at least 2
- BLOCKS_REPETITION, 8192, data blocks per flow between AM groups; one data period is 2*BLOCKS_REPETITION blocks
- AM_IDX_W, $clog2(MAX_BLOCKS_AM), width of am_idx
- CNT_W, $clog2(2*BLOCKS_REPETITION), width of the internal data counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream block valid
- in_ready  out  1  scheduler accepts in_block this cycle
- in_block  in  BITS_BLOCK  upstream data block
- am_idx  out  AM_IDX_W  index of the AM block requested from the AM generator
- am_data  in  BITS_BLOCK  AM block for am_idx; combinational lookup, sampled in the same cycle
- out_valid  out  1  output beat valid
- out_block  out  BITS_BLOCK  output block
- out_flow  out  1  target flow of the current beat
- out_is_am  out  1  current beat is an AM block
- am_start  out  1  one-cycle pulse coincident with the first AM beat of a group
- gap_cnt  out  32  count of upstream bubbles (see Configuration)

## Operation
- FSM states:
  - S_AM: emit AM group.
  - S_DATA: pass data.
- Reset enters S_AM, so the first group is emitted right after reset.
- S_AM, every cycle:
  - out_block <= am_data, out_is_am <= 1, out_valid <= 1, am_idx increments.
  - At am_idx == MAX_BLOCKS_AM-1: am_idx <= 0, data_cnt <= 0, go to S_DATA.
- S_DATA, in_valid=1:
  - out_block <= in_block, out_is_am <= 0, out_valid <= 1, data_cnt increments.
  - At data_cnt == 2*BLOCKS_REPETITION-1 (accepted beat): go to S_AM.
- S_DATA, in_valid=0:
  - out_valid <= 0, out_is_am <= 0. data_cnt, out_flow and out_block hold.
- in_ready = (state == S_DATA). It is a registered-state decode with no combinational path from in_valid.
- out_flow toggles after every emitted beat (out_valid=1), AM or data. The first beat after reset carries flow 0.
- Because MAX_BLOCKS_AM is even, every group starts on flow 0 and every data period starts on flow 0.
- am_start <= 1 only on the cycle am_idx==0 is emitted, i.e. on the first S_AM cycle.
- There is no downstream backpressure; the consumer accepts every valid beat.
- Elaboration error if MAX_BLOCKS_AM is odd or below 2, or if BLOCKS_REPETITION < 1.

## Timing
- Latency is 1 cycle: a beat accepted or requested at edge N appears on out_* after edge N.
- After the edge where rst is low for the first time:
  - S_AM emits MAX_BLOCKS_AM consecutive AM beats.
  - in_ready goes high on the first cycle after the last AM request.
- The last data acceptance (count 2*BLOCKS_REPETITION) drops in_ready on the next cycle. The AM group starts with no bubble.
- Reset values:
  - out_valid 0, out_block 0, out_flow 0, out_is_am 0, am_start 0.
  - am_idx 0, in_ready 0, gap_cnt 0.
  - State S_AM, data_cnt 0.
- rst asserted mid-group or mid-period:
  - All state returns to reset values on the next edge; a partial group is abandoned.
  - After release, a full group restarts at am_idx 0 with flow 0.
- An upstream stall on the final data block simply defers the transition; AM insertion never preempts an unfinished period.

## Configuration
- AM_SCHED_GAP_CNT_EN defined:
  - gap_cnt counts S_DATA cycles with in_valid=0.
  - It saturates at 2^32-1 and clears only on rst.
- Not defined: gap_cnt is tied to 0 and the counter is not built. All other behaviour is identical.

## Test plan
Parameters for all scenarios: BLOCKS_REPETITION=4, MAX_BLOCKS_AM=4.
- Reset release with in_valid=1 held -> 4 AM beats:
  - am_idx 0..3, out_flow 0,1,0,1, am_start on beat 0 only.
  - Then in_ready=1 and 8 data beats, flows 0,1,…,1.
  - Then the next AM group begins on flow 0.
- Continuous traffic over 3 periods -> pattern 4 AM / 8 data repeats exactly. in_ready is low during exactly 4 of every 12 cycles.
- in_valid deasserted for 3 cycles mid-period -> no out_valid for those cycles, out_flow holds, the period still ends after 8 data beats. gap_cnt=3 with AM_SCHED_GAP_CNT_EN, 0 without.
- in_valid low while 7 of 8 data accepted -> the scheduler stays in S_DATA indefinitely. The AM group starts one cycle after the 8th block is accepted.
- rst pulsed during AM beat 2 -> after release, outputs restart with am_idx 0, flow 0, am_start=1. All reset values are checked during rst.
- Data pattern in_block = beat number -> out_block matches one cycle later, with out_is_am=0 on every data beat.

Source files
------------

// File: rtl/am_flow_scheduler.sv
// am_flow_scheduler
//
// Sequences the block stream feeding the two-flow distributor. After reset,
// and after every data period of 2*BLOCKS_REPETITION accepted blocks, a group
// of MAX_BLOCKS_AM alignment-marker blocks is emitted. The upstream source is
// held off with in_ready=0 while a group is being emitted. Every emitted beat
// is tagged with its target flow, alternating 0/1 from flow 0 after reset.
//
// Optional feature (macro AM_SCHED_GAP_CNT_EN):
//   defined     -> gap_cnt counts S_DATA cycles with in_valid=0, saturating
//                  at 2^32-1, cleared only by rst.
//   not defined -> gap_cnt is tied to 0.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   in_valid   upstream block valid
//   in_ready   scheduler accepts in_block this cycle (decode of state only)
//   in_block   upstream data block
//   am_idx     index of the AM block requested from the AM generator
//   am_data    AM block for am_idx (combinational lookup, same cycle)
//   out_valid  output beat valid
//   out_block  output block
//   out_flow   target flow of the current beat
//   out_is_am  current beat is an AM block
//   am_start   one-cycle pulse with the first AM beat of a group
//   gap_cnt    upstream bubble count (see above)

module am_flow_scheduler #(
  parameter int BITS_BLOCK        = 257,
  parameter int MAX_BLOCKS_AM     = 40,
  parameter int BLOCKS_REPETITION = 8192,
  parameter int AM_IDX_W          = $clog2(MAX_BLOCKS_AM),
  parameter int CNT_W             = $clog2(2 * BLOCKS_REPETITION)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS_BLOCK-1:0] in_block,
  output logic [AM_IDX_W-1:0]   am_idx,
  input  logic [BITS_BLOCK-1:0] am_data,
  output logic                  out_valid,
  output logic [BITS_BLOCK-1:0] out_block,
  output logic                  out_flow,
  output logic                  out_is_am,
  output logic                  am_start,
  output logic [31:0]           gap_cnt
);

  // An odd group would leave the following data period starting on flow 1.
  generate
    if ((MAX_BLOCKS_AM % 2) != 0 || MAX_BLOCKS_AM < 2 || BLOCKS_REPETITION < 1) begin : g_param_err
      $error("am_flow_scheduler: MAX_BLOCKS_AM must be even and >= 2, BLOCKS_REPETITION >= 1");
    end
  endgenerate

  localparam logic [AM_IDX_W-1:0] AM_LAST  = AM_IDX_W'(MAX_BLOCKS_AM - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(2 * BLOCKS_REPETITION - 1);

  typedef enum logic {
    S_AM   = 1'b0,
    S_DATA = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_d;
  logic [AM_IDX_W-1:0]     am_idx_d;
  logic [CNT_W-1:0]        data_cnt;
  logic [CNT_W-1:0]        data_cnt_d;
  // Flow the next emitted beat will carry; out_flow holds the last one.
  logic                    flow_nxt;
  logic                    flow_nxt_d;

  logic                    vld_p0;
  logic [BITS_BLOCK-1:0]   blk_p0;
  logic                    flow_p0;
  logic                    is_am_p0;
  logic                    start_p0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  assign in_ready = (state == S_DATA);

  always_comb begin
    state_d    = state;
    am_idx_d   = am_idx;
    data_cnt_d = data_cnt;
    flow_nxt_d = flow_nxt;
    vld_p0     = 1'b0;
    blk_p0     = out_block;
    flow_p0    = out_flow;
    is_am_p0   = 1'b0;
    start_p0   = 1'b0;

    unique case (state)
      S_AM: begin
        vld_p0     = 1'b1;
        blk_p0     = am_data;
        is_am_p0   = 1'b1;
        start_p0   = (am_idx == '0);
        flow_p0    = flow_nxt;
        flow_nxt_d = ~flow_nxt;
        if (am_idx == AM_LAST) begin
          am_idx_d   = '0;
          data_cnt_d = '0;
          state_d    = S_DATA;
        end else begin
          am_idx_d = am_idx + AM_IDX_W'(1);
        end
      end

      S_DATA: begin
        if (in_valid) begin
          vld_p0     = 1'b1;
          blk_p0     = in_block;
          flow_p0    = flow_nxt;
          flow_nxt_d = ~flow_nxt;
          if (data_cnt == CNT_LAST) begin
            data_cnt_d = '0;
            state_d    = S_AM;
          end else begin
            data_cnt_d = data_cnt + CNT_W'(1);
          end
        end
      end

      default: state_d = S_AM;
    endcase
  end

  // ---- p0 -> output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_AM;
      am_idx    <= '0;
      data_cnt  <= '0;
      flow_nxt  <= 1'b0;
      out_valid <= 1'b0;
      out_block <= '0;
      out_flow  <= 1'b0;
      out_is_am <= 1'b0;
      am_start  <= 1'b0;
    end else begin
      state     <= state_d;
      am_idx    <= am_idx_d;
      data_cnt  <= data_cnt_d;
      flow_nxt  <= flow_nxt_d;
      out_valid <= vld_p0;
      out_block <= blk_p0;
      out_flow  <= flow_p0;
      out_is_am <= is_am_p0;
      am_start  <= start_p0;
    end
  end

`ifdef AM_SCHED_GAP_CNT_EN
  logic [31:0] gap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else if (state == S_DATA && !in_valid) begin
      gap_q <= sat_inc32(gap_q);
    end
  end

  assign gap_cnt = gap_q;
`else
  assign gap_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_am_flow_scheduler.sv
// Testbench for am_flow_scheduler with BLOCKS_REPETITION=4, MAX_BLOCKS_AM=4.
// A transaction-level model predicts each cycle's outputs when the inputs are
// driven and queues them; a monitor pops and compares after the clock edge.

module tb_am_flow_scheduler;

  localparam int BW    = 257;
  localparam int MAXAM = 4;
  localparam int BR    = 4;
  localparam int AIW   = 2;
  localparam int CW    = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BW-1:0]   in_block;
  logic [AIW-1:0]  am_idx;
  logic [BW-1:0]   am_data;
  logic            out_valid;
  logic [BW-1:0]   out_block;
  logic            out_flow;
  logic            out_is_am;
  logic            am_start;
  logic [31:0]     gap_cnt;

  always #5 clk = ~clk;

  am_flow_scheduler #(
    .BITS_BLOCK       (BW),
    .MAX_BLOCKS_AM    (MAXAM),
    .BLOCKS_REPETITION(BR),
    .AM_IDX_W         (AIW),
    .CNT_W            (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_block (in_block),
    .am_idx   (am_idx),
    .am_data  (am_data),
    .out_valid(out_valid),
    .out_block(out_block),
    .out_flow (out_flow),
    .out_is_am(out_is_am),
    .am_start (am_start),
    .gap_cnt  (gap_cnt)
  );

  function automatic logic [BW-1:0] amgen(input logic [AIW-1:0] i);
    return {1'b1, 224'h0, 16'hA1A1, 14'h0, i};
  endfunction

  assign am_data = amgen(am_idx);

  typedef struct packed {
    logic           valid;
    logic [BW-1:0]  block;
    logic           flow;
    logic           is_am;
    logic           start;
    logic           ready;
    logic [AIW-1:0] idx;
    logic [31:0]    gap;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit            m_am   = 1'b1;
  int            m_idx  = 0;
  int            m_cnt  = 0;
  bit            m_flow = 1'b0;
  bit            m_oflow = 1'b0;
  logic [BW-1:0] m_blk  = '0;
  logic [31:0]   m_gap  = '0;
  int            beat   = 0;

  // Called at a falling edge: drive inputs, predict the result of the next
  // rising edge, queue it, then advance to the next falling edge.
  task automatic step(input bit r, input bit v);
    exp_t          e;
    logic [BW-1:0] blk;
    blk      = BW'(beat) + {1'b0, 200'h0, 56'hD0_0000_0000_0000};
    beat++;
    rst      = r;
    in_valid = v;
    in_block = blk;
    e        = '0;
    if (r) begin
      m_am = 1'b1; m_idx = 0; m_cnt = 0; m_flow = 1'b0; m_oflow = 1'b0;
      m_blk = '0; m_gap = '0;
    end else if (m_am) begin
      e.valid = 1'b1;
      e.block = amgen(AIW'(m_idx));
      e.flow  = m_flow;
      e.is_am = 1'b1;
      e.start = (m_idx == 0);
      m_blk   = e.block;
      m_oflow = m_flow;
      m_flow  = !m_flow;
      m_idx++;
      if (m_idx == MAXAM) begin
        m_idx = 0; m_cnt = 0; m_am = 1'b0;
      end
    end else if (v) begin
      e.valid = 1'b1;
      e.block = blk;
      e.flow  = m_flow;
      m_blk   = blk;
      m_oflow = m_flow;
      m_flow  = !m_flow;
      m_cnt++;
      if (m_cnt == 2 * BR) m_am = 1'b1;
    end else begin
      e.block = m_blk;
      e.flow  = m_oflow;
`ifdef AM_SCHED_GAP_CNT_EN
      if (m_gap != 32'hFFFF_FFFF) m_gap = m_gap + 32'd1;
`endif
    end
    e.ready = !m_am;
    e.idx   = AIW'(m_idx);
    e.gap   = m_gap;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  always begin : mon
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("out_valid", out_valid, e.valid);
      chk("out_block", out_block, e.block);
      chk("out_flow",  out_flow,  e.flow);
      chk("out_is_am", out_is_am, e.is_am);
      chk("am_start",  am_start,  e.start);
      chk("in_ready",  in_ready,  e.ready);
      chk("am_idx",    am_idx,    e.idx);
      chk("gap_cnt",   gap_cnt,   e.gap);
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_block = '0;
    @(negedge clk);

    // Reset values held for several cycles
    repeat (3) step(1'b1, 1'b0);
    // First group, then three full periods of continuous traffic
    repeat (36) step(1'b0, 1'b1);
    // Group + 3 data, 3-cycle upstream stall, then finish the period
    repeat (7) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    // Group + 7 data, long stall before the final block, then the final block
    repeat (4) step(1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    // Next group: two AM beats, then reset lands on AM beat 2
    repeat (2) step(1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b1);
    repeat (14) step(1'b0, 1'b1);
    // Random upstream valid
    repeat (60) step(1'b0, 1'($urandom_range(0, 1)));

    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
